data_mem_port_rv32i: RTL and testbench

//  Memory-stage data-memory port of the RV32I pipeline. Converts the M-stage load/store into a
//  req/ack bus transaction, and formats store byte-lanes and load results (sign/zero extension).

---
 rtl/rv32i_mem_pkg.sv | 31 +++
 rtl/load_formatter_rv32i.sv | 37 +++
 rtl/data_mem_port_rv32i.sv | 149 ++++++++++++++
 tb/tb_data_mem_port_rv32i.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module : rv32i_mem_pkg
//  Brief  : Shared funct3 codes, port FSM states and byte-enable helper for
//           the RV32I data-memory port.
//  Rev    : 1.0  initial release
// ============================================================================
package rv32i_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_LB:   store_be = 4'b0001 << off;
            F3_LH:   store_be = 4'b0011 << off;
            default: store_be = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_formatter_rv32i.sv
`default_nettype none
// ============================================================================
//  Module : load_formatter_rv32i
//  Brief  : Selects the addressed byte/half of a raw bus word and sign- or
//           zero-extends it to 32 bits.
//  Rev    : 1.0  initial release
// ============================================================================
module load_formatter_rv32i
    import rv32i_mem_pkg::*;
(
    input  logic [31:0] i_raw_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_raw_word >> {i_offset, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_offset[1] ? i_raw_word[31:16] : i_raw_word[15:0];

    always_comb begin
        o_result = i_raw_word;
        case (i_funct3)
            F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_result = {24'd0, w_byte};
            F3_LH:   o_result = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_result = {16'd0, w_half};
            default: o_result = i_raw_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_port_rv32i.sv
`default_nettype none
// ============================================================================
//  Module : data_mem_port_rv32i
//  Brief  : M-stage data-memory port: turns a load/store into a req/ack bus
//           cycle with lane formatting, load extension and an ack watchdog.
//  Rev    : 1.0  initial release
// ============================================================================
module data_mem_port_rv32i
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_M,
    input  logic              mem_write_M,
    input  logic [2:0]        funct3_M,
    input  logic [ADDR_W-1:0] addr_M,
    input  logic [31:0]       wdata_M,
    input  logic              enable_memory,
    output logic              mem_transaction,
    output logic              data_ready,
    output logic [31:0]       rdata_M,
    output logic              misaligned_M,
    output logic              bus_error,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int c_WD_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = (ACK_TIMEOUT > 0) ? c_WD_W'(ACK_TIMEOUT - 1) : '0;
    localparam logic [c_WD_W-1:0] c_WD_MAX  = '1;

    dmem_state_t       r_state, w_next;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;
    logic [c_WD_W-1:0] r_wd_cnt;
    logic              w_bad;
    logic              w_wd_expire;
    logic [31:0]       w_store_data;
    logic [31:0]       w_load_data;

    // Byte-half/byte stores are legal only with the signed funct3 codes.
    always_comb begin
        w_bad = 1'b0;
        case (funct3_M)
            F3_LB:   w_bad = 1'b0;
            F3_LBU:  w_bad = mem_write_M;
            F3_LH:   w_bad = addr_M[0];
            F3_LHU:  w_bad = addr_M[0] | mem_write_M;
            F3_LW:   w_bad = (addr_M[1:0] != 2'b00);
            default: w_bad = 1'b1;
        endcase
    end

    assign misaligned_M    = (mem_read_M | mem_write_M) & w_bad;
    assign mem_transaction = (mem_read_M | mem_write_M) & ~misaligned_M;

    // Expiry fires on the ACK_TIMEOUT-th REQ cycle.
    assign w_wd_expire = (ACK_TIMEOUT != 0) && (r_wd_cnt >= c_WD_LAST);

    always_comb begin
        w_store_data = wdata_M;
        case (funct3_M)
            F3_LB:   w_store_data = {4{wdata_M[7:0]}};
            F3_LH:   w_store_data = {2{wdata_M[15:0]}};
            default: w_store_data = wdata_M;
        endcase
    end

    load_formatter_rv32i u_load_formatter (
        .i_raw_word (bus_rdata),
        .i_offset   (r_off),
        .i_funct3   (r_funct3),
        .o_result   (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (mem_transaction)        w_next = REQ;
            REQ:     if (bus_ack || w_wd_expire) w_next = DONE;
            DONE:    if (enable_memory)          w_next = IDLE;
            default:                             w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            data_ready <= 1'b0;
            rdata_M    <= '0;
            bus_error  <= 1'b0;
            r_off      <= '0;
            r_funct3   <= '0;
            r_wd_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_transaction) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write_M;
                        bus_addr  <= {addr_M[ADDR_W-1:2], 2'b00};
                        bus_be    <= mem_write_M ? store_be(funct3_M, addr_M[1:0]) : 4'b1111;
                        bus_wdata <= w_store_data;
                        r_off     <= addr_M[1:0];
                        r_funct3  <= funct3_M;
                        r_wd_cnt  <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        rdata_M    <= bus_we ? 32'd0 : w_load_data;
                        data_ready <= 1'b1;
                    end else if (w_wd_expire) begin
                        bus_req    <= 1'b0;
                        rdata_M    <= 32'd0;
                        bus_error  <= 1'b1;
                        data_ready <= 1'b1;
                    end else if (r_wd_cnt != c_WD_MAX) begin
                        r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                    end
                end
                DONE: begin
                    if (enable_memory) data_ready <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_port_rv32i.sv
`default_nettype none
// ============================================================================
//  Module : tb_data_mem_port_rv32i
//  Brief  : Directed self-checking bench for data_mem_port_rv32i.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_port_rv32i;

    localparam int c_ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read_M, mem_write_M, enable_memory;
    logic [2:0]        funct3_M;
    logic [c_ADDR_W-1:0] addr_M;
    logic [31:0]       wdata_M;
    logic              mem_transaction, data_ready, misaligned_M, bus_error;
    logic [31:0]       rdata_M, bus_wdata, bus_rdata;
    logic              bus_req, bus_we, bus_ack;
    logic [c_ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;

    int errors = 0;
    int checks = 0;

    data_mem_port_rv32i #(.ADDR_W(c_ADDR_W), .ACK_TIMEOUT(4)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read_M      (mem_read_M),
        .mem_write_M     (mem_write_M),
        .funct3_M        (funct3_M),
        .addr_M          (addr_M),
        .wdata_M         (wdata_M),
        .enable_memory   (enable_memory),
        .mem_transaction (mem_transaction),
        .data_ready      (data_ready),
        .rdata_M         (rdata_M),
        .misaligned_M    (misaligned_M),
        .bus_error       (bus_error),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_be          (bus_be),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an access to M and steps into the first REQ cycle.
    task automatic start(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        mem_read_M  = rd;
        mem_write_M = wr;
        funct3_M    = f3;
        addr_M      = addr;
        wdata_M     = wd;
        tick();
    endtask

    // Acks on the n-th REQ cycle; returns positioned in DONE.
    task automatic ack_after(input int n, input logic [31:0] data);
        repeat (n - 1) tick();
        bus_ack   = 1'b1;
        bus_rdata = data;
        tick();
        bus_ack   = 1'b0;
    endtask

    task automatic finish_access();
        mem_read_M    = 1'b0;
        mem_write_M   = 1'b0;
        enable_memory = 1'b1;
        tick();
        enable_memory = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int req_seen;
        int rdy_seen;
        logic [31:0] held;

        rst = 1'b1; mem_read_M = 0; mem_write_M = 0; enable_memory = 0;
        funct3_M = 0; addr_M = 0; wdata_M = 0; bus_ack = 0; bus_rdata = 0;
        tick(); tick();
        check_eq("rst_bus_req",    {31'd0, bus_req},    32'd0);
        check_eq("rst_bus_addr",   bus_addr,            32'd0);
        check_eq("rst_bus_be",     {28'd0, bus_be},     32'd0);
        check_eq("rst_data_ready", {31'd0, data_ready}, 32'd0);
        check_eq("rst_rdata",      rdata_M,             32'd0);
        check_eq("rst_bus_error",  {31'd0, bus_error},  32'd0);
        rst = 1'b0;
        tick();

        // LW, ack on second REQ cycle
        mem_read_M = 1; funct3_M = 3'b010; addr_M = 32'h100;
        #1 check_eq("lw_mem_trans", {31'd0, mem_transaction}, 32'd1);
        check_eq("lw_req_latency", {31'd0, bus_req}, 32'd0);
        tick();
        check_eq("lw_bus_req",  {31'd0, bus_req}, 32'd1);
        check_eq("lw_bus_addr", bus_addr, 32'h100);
        check_eq("lw_bus_be",   {28'd0, bus_be}, 32'hF);
        check_eq("lw_bus_we",   {31'd0, bus_we}, 32'd0);
        ack_after(2, 32'hDEADBEEF);
        check_eq("lw_ready", {31'd0, data_ready}, 32'd1);
        check_eq("lw_rdata", rdata_M, 32'hDEADBEEF);
        check_eq("lw_req_drop", {31'd0, bus_req}, 32'd0);
        finish_access();
        check_eq("lw_ready_clr", {31'd0, data_ready}, 32'd0);

        // Byte/half loads with extension
        start(1, 0, 3'b000, 32'h103, 0);
        check_eq("lb_bus_addr", bus_addr, 32'h100);
        ack_after(1, 32'h80123456);
        check_eq("lb_rdata", rdata_M, 32'hFFFFFF80);
        finish_access();
        start(1, 0, 3'b100, 32'h103, 0);
        ack_after(1, 32'h80123456);
        check_eq("lbu_rdata", rdata_M, 32'h00000080);
        finish_access();
        start(1, 0, 3'b001, 32'h102, 0);
        ack_after(1, 32'h7FFF0000);
        check_eq("lh_hi_rdata", rdata_M, 32'h00007FFF);
        finish_access();
        start(1, 0, 3'b001, 32'h100, 0);
        ack_after(1, 32'h12348001);
        check_eq("lh_lo_rdata", rdata_M, 32'hFFFF8001);
        finish_access();
        start(1, 0, 3'b101, 32'h100, 0);
        ack_after(1, 32'h1234F00D);
        check_eq("lhu_rdata", rdata_M, 32'h0000F00D);
        finish_access();

        // Stores
        start(0, 1, 3'b001, 32'h202, 32'h1234ABCD);
        check_eq("sh_bus_we",    {31'd0, bus_we}, 32'd1);
        check_eq("sh_bus_be",    {28'd0, bus_be}, 32'hC);
        check_eq("sh_bus_wdata", bus_wdata, 32'hABCDABCD);
        check_eq("sh_bus_addr",  bus_addr, 32'h200);
        ack_after(1, 32'hFFFFFFFF);
        check_eq("sh_rdata_zero", rdata_M, 32'd0);
        finish_access();
        start(0, 1, 3'b000, 32'h001, 32'h0000005A);
        check_eq("sb_bus_be",    {28'd0, bus_be}, 32'h2);
        check_eq("sb_bus_wdata", bus_wdata, 32'h5A5A5A5A);
        ack_after(1, 32'h0);
        finish_access();

        // Misaligned / reserved: no bus request
        mem_read_M = 1; funct3_M = 3'b010; addr_M = 32'h101;
        #1 check_eq("lw_mis_flag",  {31'd0, misaligned_M},    32'd1);
        check_eq("lw_mis_trans", {31'd0, mem_transaction}, 32'd0);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_req) req_seen++;
        end
        check_eq("lw_mis_no_req", req_seen, 32'd0);
        funct3_M = 3'b001; addr_M = 32'h103;
        #1 check_eq("lh_mis_flag", {31'd0, misaligned_M}, 32'd1);
        funct3_M = 3'b011; addr_M = 32'h100;
        #1 check_eq("rsvd_f3_flag", {31'd0, misaligned_M}, 32'd1);
        funct3_M = 3'b000; addr_M = 32'h103;
        #1 check_eq("lb_odd_ok", {31'd0, misaligned_M}, 32'd0);
        mem_read_M = 0;
        tick();

        // Watchdog expiry: no ack for 4 REQ cycles
        start(1, 0, 3'b010, 32'h300, 0);
        repeat (3) tick();
        check_eq("wd_req_held", {31'd0, bus_req}, 32'd1);
        tick();
        check_eq("wd_req_drop", {31'd0, bus_req},    32'd0);
        check_eq("wd_error",    {31'd0, bus_error},  32'd1);
        check_eq("wd_ready",    {31'd0, data_ready}, 32'd1);
        check_eq("wd_rdata",    rdata_M, 32'd0);
        finish_access();
        check_eq("wd_error_sticky", {31'd0, bus_error}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check_eq("wd_error_rst", {31'd0, bus_error}, 32'd0);

        // Ack coincident with expiry wins
        start(1, 0, 3'b010, 32'h304, 0);
        ack_after(4, 32'hCAFEF00D);
        check_eq("wd_tie_error", {31'd0, bus_error},  32'd0);
        check_eq("wd_tie_ready", {31'd0, data_ready}, 32'd1);
        check_eq("wd_tie_rdata", rdata_M, 32'hCAFEF00D);
        finish_access();

        // Reset during REQ, then a stray ack
        start(1, 0, 3'b010, 32'h400, 0);
        check_eq("rstreq_req_up", {31'd0, bus_req}, 32'd1);
        rst = 1'b1; mem_read_M = 1'b0;
        #1 check_eq("rstreq_req_drop", {31'd0, bus_req}, 32'd0);
        tick();
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        tick();
        bus_ack = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (data_ready || bus_req) rdy_seen++;
            tick();
        end
        check_eq("rstreq_no_ready", rdy_seen, 32'd0);

        // DONE held with enable_memory low; exit does not reissue same cycle
        start(1, 0, 3'b010, 32'h500, 0);
        ack_after(1, 32'h11223344);
        held = rdata_M;
        check_eq("hold_rdata0", held, 32'h11223344);
        req_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_req || !data_ready || rdata_M !== 32'h11223344) req_seen++;
        end
        check_eq("hold_stable", req_seen, 32'd0);
        enable_memory = 1'b1;
        addr_M = 32'h504;
        tick();
        enable_memory = 1'b0;
        check_eq("exit_ready_clr", {31'd0, data_ready}, 32'd0);
        check_eq("exit_no_req",    {31'd0, bus_req},    32'd0);
        tick();
        check_eq("next_req",      {31'd0, bus_req}, 32'd1);
        check_eq("next_bus_addr", bus_addr, 32'h504);
        ack_after(1, 32'h0);
        finish_access();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
